// File: rtl/key_pkg.sv
// Shared definitions for the multi-key debouncer.
//   hold_state_e        : per-key hold tracking states (idle / held / long)
//   DEF_*_CYCLES        : default timing constants for a 100 MHz clk
//   timing_params_ok()  : legality check used at elaboration by the top
package key_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } hold_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;    // 10 ms
   localparam int DEF_LONG_CYCLES     = 100_000_000;  // 1 s
   localparam int DEF_REPEAT_CYCLES   = 20_000_000;   // 200 ms

   function automatic bit timing_params_ok(input int deb, input int lng, input int rpt);
      return (deb >= 2) && (lng > deb) && (rpt >= 2);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-FF synchroniser, debounce counter, registered
// debounced level, press/release edge pulses and the hold FSM that produces
// long-press and auto-repeat pulses.
//   clk       : system clock
//   rst       : synchronous reset, active-high
//   key_i     : raw asynchronous pin
//   level_o   : debounced level, 1 = pressed
//   press_o   : 1-cycle pulse on debounced press
//   release_o : 1-cycle pulse on debounced release
//   long_o    : 1-cycle pulse when a hold reaches LONG_CYCLES
//   rpt_o     : 1-cycle pulse every REPEAT_CYCLES while in long hold
//
// Hold FSM
//   state   | meaning
//   ST_IDLE | key released (or press not yet seen)
//   ST_HELD | key pressed, hcnt counting towards the long-press threshold
//   ST_LONG | long press reached, rcnt paces the auto-repeat pulses
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int REPEAT_EN       = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic rpt_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES);
   localparam int RW = $clog2(REPEAT_CYCLES);

   localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] H_LAST   = HW'(LONG_CYCLES - 1);
   localparam logic [RW-1:0] R_LAST   = RW'(REPEAT_CYCLES - 1);
   localparam logic          IDLE_PIN = (ACTIVE_LOW != 0);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          level_q, level_prev_q;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;
   logic          rpt_q, rpt_d;
   hold_state_e   state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          pressed_now;

   // Normalise polarity so that 1 always means pressed from here on.
   assign pressed_now = sync2_q ^ IDLE_PIN;

   always_comb begin
      stable_d  = stable_q;
      dcnt_d    = '0;
      press_d   = level_q & ~level_prev_q;
      release_d = ~level_q & level_prev_q;
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      rcnt_d    = rcnt_q;
      long_d    = 1'b0;
      rpt_d     = 1'b0;

      // Any cycle that agrees with the stable level leaves dcnt at 0,
      // so a bounce restarts the count.
      if (pressed_now != stable_q) begin
         if (dcnt_q == D_LAST) begin
            stable_d = ~stable_q;
         end else begin
            dcnt_d = dcnt_q + 1'b1;
         end
      end

      // The FSM follows the registered level; a low level forces idle in the
      // same cycle the release pulse is produced, suppressing long/rpt there.
      if (!level_q) begin
         state_d = ST_IDLE;
         hcnt_d  = '0;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (press_d) begin
                  state_d = ST_HELD;
                  hcnt_d  = '0;
               end
            end
            ST_HELD: begin
               if (hcnt_q == H_LAST) begin
                  state_d = ST_LONG;
                  long_d  = 1'b1;
                  hcnt_d  = '0;
                  rcnt_d  = '0;
               end else begin
                  hcnt_d = hcnt_q + 1'b1;
               end
            end
            ST_LONG: begin
               if (REPEAT_EN != 0) begin
                  if (rcnt_q == R_LAST) begin
                     rcnt_d = '0;
                     rpt_d  = 1'b1;
                  end else begin
                     rcnt_d = rcnt_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= IDLE_PIN;
         sync2_q      <= IDLE_PIN;
         stable_q     <= 1'b0;
         dcnt_q       <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
         long_q       <= 1'b0;
         rpt_q        <= 1'b0;
         state_q      <= ST_IDLE;
         hcnt_q       <= '0;
         rcnt_q       <= '0;
      end else begin
         sync1_q      <= key_i;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         dcnt_q       <= dcnt_d;
         level_q      <= stable_q;
         level_prev_q <= level_q;
         press_q      <= press_d;
         release_q    <= release_d;
         long_q       <= long_d;
         rpt_q        <= rpt_d;
         state_q      <= state_d;
         hcnt_q       <= hcnt_d;
         rcnt_q       <= rcnt_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;
   assign rpt_o     = rpt_q;

endmodule

// File: rtl/multi_key_debounce.sv
// N-channel push-button conditioner: one key_debounce_ch per key plus an
// any-key-pressed summary.
//   clk           : system clock
//   rst           : synchronous reset, active-high
//   key_in        : raw asynchronous button pins
//   key_level     : debounced state per key, 1 = pressed
//   press_pulse   : 1-cycle pulse per key on debounced press
//   release_pulse : 1-cycle pulse per key on debounced release
//   long_pulse    : 1-cycle pulse per key when a hold reaches LONG_CYCLES
//   rpt_pulse     : 1-cycle auto-repeat pulses per key after long_pulse
//   any_pressed   : OR of key_level (built only from registered levels)
module multi_key_debounce
   import key_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int REPEAT_EN       = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_pulse,
   output logic [N_KEYS-1:0] rpt_pulse,
   output logic              any_pressed
);

   if (!timing_params_ok(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)) begin : g_param_check
      $error("multi_key_debounce: illegal timing parameters");
   end

   for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
      key_debounce_ch #(
         .ACTIVE_LOW      (ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES),
         .REPEAT_EN       (REPEAT_EN)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .key_i     (key_in[k]),
         .level_o   (key_level[k]),
         .press_o   (press_pulse[k]),
         .release_o (release_pulse[k]),
         .long_o    (long_pulse[k]),
         .rpt_o     (rpt_pulse[k])
      );
   end

   assign any_pressed = |key_level;

endmodule

// File: tb/tb_multi_key_debounce.sv
module tb_multi_key_debounce;

   localparam int D  = 8;
   localparam int L  = 40;
   localparam int R  = 10;
   localparam int NK = 4;
   localparam int HL = D + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NK-1:0] pins  [2];
   logic [NK-1:0] o_lvl [2];
   logic [NK-1:0] o_prs [2];
   logic [NK-1:0] o_rel [2];
   logic [NK-1:0] o_lng [2];
   logic [NK-1:0] o_rpt [2];
   logic          o_any [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multi_key_debounce #(.N_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
                        .LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1)) ua (
      .clk(clk), .rst(rst), .key_in(pins[0]), .key_level(o_lvl[0]),
      .press_pulse(o_prs[0]), .release_pulse(o_rel[0]), .long_pulse(o_lng[0]),
      .rpt_pulse(o_rpt[0]), .any_pressed(o_any[0]));

   multi_key_debounce #(.N_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
                        .LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(0)) ub (
      .clk(clk), .rst(rst), .key_in(pins[1]), .key_level(o_lvl[1]),
      .press_pulse(o_prs[1]), .release_pulse(o_rel[1]), .long_pulse(o_lng[1]),
      .rpt_pulse(o_rpt[1]), .any_pressed(o_any[1]));

   // Reference model: a level flips when the D most recent synchronised
   // samples all disagree with it; pulses follow from level history and
   // hold time measured in cycles since the press pulse.
   bit            m_hist   [2][NK][HL];
   bit            m_stable [2][NK];
   bit            m_lvl    [2][NK];
   bit            m_prev   [2][NK];
   bit            m_hold   [2][NK];
   int            m_pt     [2][NK];
   logic [NK-1:0] e_lvl [2], e_prs [2], e_rel [2], e_lng [2], e_rpt [2];
   int            cyc = 0;
   bit            rep_en [2] = '{1'b1, 1'b0};

   always @(posedge clk) begin : model
      int  d;
      bit  all_diff, ol, op;
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < NK; k++) begin
            e_lng[i][k] = 1'b0;
            e_rpt[i][k] = 1'b0;
            if (rst) begin
               for (int h = 0; h < HL; h++) m_hist[i][k][h] = 1'b0;
               m_stable[i][k] = 1'b0;
               m_lvl[i][k]    = 1'b0;
               m_prev[i][k]   = 1'b0;
               m_hold[i][k]   = 1'b0;
               e_prs[i][k]    = 1'b0;
               e_rel[i][k]    = 1'b0;
            end else begin
               for (int h = 0; h < HL - 1; h++) m_hist[i][k][h] = m_hist[i][k][h+1];
               m_hist[i][k][HL-1] = ~pins[i][k];
               all_diff = 1'b1;
               for (int h = 0; h < D; h++)
                  if (m_hist[i][k][h] == m_stable[i][k]) all_diff = 1'b0;
               ol = m_lvl[i][k];
               op = m_prev[i][k];
               m_prev[i][k] = ol;
               m_lvl[i][k]  = m_stable[i][k];
               if (all_diff) m_stable[i][k] = ~m_stable[i][k];
               e_prs[i][k] = ol & ~op;
               e_rel[i][k] = ~ol & op;
               if (!ol) begin
                  m_hold[i][k] = 1'b0;
               end else if (e_prs[i][k]) begin
                  m_hold[i][k] = 1'b1;
                  m_pt[i][k]   = cyc;
               end else if (m_hold[i][k]) begin
                  d = cyc - m_pt[i][k];
                  e_lng[i][k] = (d == L);
                  e_rpt[i][k] = rep_en[i] && (d > L) && (((d - L) % R) == 0);
               end
            end
            e_lvl[i][k] = m_lvl[i][k];
         end
      end
   end

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", nm, inst, $time, act, exp);
      end
   endtask

   task automatic sb_compare();
      for (int i = 0; i < 2; i++) begin
         chk("sb_level",   i, 32'(o_lvl[i]), 32'(e_lvl[i]));
         chk("sb_press",   i, 32'(o_prs[i]), 32'(e_prs[i]));
         chk("sb_release", i, 32'(o_rel[i]), 32'(e_rel[i]));
         chk("sb_long",    i, 32'(o_lng[i]), 32'(e_lng[i]));
         chk("sb_rpt",     i, 32'(o_rpt[i]), 32'(e_rpt[i]));
         chk("sb_any",     i, 32'(o_any[i]), 32'(|e_lvl[i]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sb_compare();
   endtask

   task automatic ticks(input int n);
      for (int j = 0; j < n; j++) tick();
   endtask

   typedef struct {
      logic [NK-1:0] pin;
      int            wait_c;
      logic [NK-1:0] exp_lvl;
      logic          exp_any;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin : main
      bit   found;
      logic acc;
      int   long_off, first_rpt, n_rpt, n_long, rpt_after_rel;
      bit   rel_seen;
      int   rem [2][NK];

      vecs[0] = '{4'b1111, 15, 4'b0000, 1'b0};
      vecs[1] = '{4'b1110, 15, 4'b0001, 1'b1};
      vecs[2] = '{4'b1100, 15, 4'b0011, 1'b1};
      vecs[3] = '{4'b0101, 15, 4'b1010, 1'b1};
      vecs[4] = '{4'b0000, 15, 4'b1111, 1'b1};
      vecs[5] = '{4'b1111, 15, 4'b0000, 1'b0};
      vecs[6] = '{4'b1011, 15, 4'b0100, 1'b1};
      vecs[7] = '{4'b1111, 15, 4'b0000, 1'b0};

      pins[0] = 4'hF;
      pins[1] = 4'hF;
      rst = 1'b1;
      ticks(3);
      chk("reset_level", 0, 32'(o_lvl[0]), 32'h0);
      chk("reset_any",   0, 32'(o_any[0]), 32'h0);
      rst = 1'b0;
      ticks(5);

      // Table of steady-state levels
      for (int v = 0; v < 8; v++) begin
         pins[0] = vecs[v].pin;
         ticks(vecs[v].wait_c);
         chk("tbl_level", v, 32'(o_lvl[0]), 32'(vecs[v].exp_lvl));
         chk("tbl_any",   v, 32'(o_any[0]), 32'(vecs[v].exp_any));
      end
      ticks(10);

      // Clean press latency on key 0
      pins[0][0] = 1'b0;
      for (int j = 0; j <= 12; j++) begin
         tick();
         if (j == 9)  chk("t1_level_early", j, 32'(o_lvl[0]), 32'h0);
         if (j == 10) chk("t1_level",       j, 32'(o_lvl[0]), 32'h1);
         if (j == 10) chk("t1_press_early", j, 32'(o_prs[0]), 32'h0);
         if (j == 11) chk("t1_press",       j, 32'(o_prs[0]), 32'h1);
         if (j == 12) chk("t1_press_end",   j, 32'(o_prs[0]), 32'h0);
      end
      pins[0][0] = 1'b1;
      ticks(25);

      // Glitches on key 1 never reach the level
      acc = 1'b0;
      pins[0][1] = 1'b0;
      for (int j = 0; j < 5; j++) begin tick(); acc |= o_lvl[0][1] | o_prs[0][1] | o_rel[0][1]; end
      pins[0][1] = 1'b1;
      for (int j = 0; j < 2; j++) begin tick(); acc |= o_lvl[0][1] | o_prs[0][1] | o_rel[0][1]; end
      pins[0][1] = 1'b0;
      for (int j = 0; j < 5; j++) begin tick(); acc |= o_lvl[0][1] | o_prs[0][1] | o_rel[0][1]; end
      pins[0][1] = 1'b1;
      for (int j = 0; j < 25; j++) begin tick(); acc |= o_lvl[0][1] | o_prs[0][1] | o_rel[0][1]; end
      chk("t2_glitch_quiet", 0, 32'(acc), 32'h0);

      // Long press and auto-repeat on key 2
      pins[0][2] = 1'b0;
      found = 1'b0;
      for (int j = 0; j < 30; j++) begin
         tick();
         if (o_prs[0][2]) begin found = 1'b1; break; end
      end
      chk("t3_press_seen", 0, 32'(found), 32'h1);
      long_off = -1; first_rpt = -1; n_rpt = 0; n_long = 0; rpt_after_rel = 0; rel_seen = 1'b0;
      for (int j = 1; j <= 130; j++) begin
         if (j == 96) pins[0][2] = 1'b1;
         tick();
         if (o_lng[0][2]) begin n_long++; long_off = j; end
         if (o_rpt[0][2]) begin
            n_rpt++;
            if (first_rpt < 0) first_rpt = j;
            if (rel_seen) rpt_after_rel++;
         end
         if (o_rel[0][2]) rel_seen = 1'b1;
      end
      chk("t3_long_offset", 0, 32'(long_off), 32'(L));
      chk("t3_long_count",  0, 32'(n_long), 32'h1);
      chk("t3_first_rpt",   0, 32'(first_rpt), 32'(L + R));
      chk("t3_rpt_count",   0, 32'(n_rpt), 32'd6);
      chk("t3_release",     0, 32'(rel_seen), 32'h1);
      chk("t3_rpt_after",   0, 32'(rpt_after_rel), 32'h0);
      pins[0][2] = 1'b1;
      ticks(10);

      // Simultaneous press on keys 0 and 3
      pins[0] = 4'b0110;
      found = 1'b0;
      for (int j = 0; j < 20; j++) begin
         tick();
         if (o_prs[0][0] | o_prs[0][3]) begin found = 1'b1; break; end
      end
      chk("t4_press_pair", 0, 32'(o_prs[0] & 4'b1001), 32'h9);
      pins[0] = 4'b0111;
      ticks(20);
      chk("t4_any_one_held", 0, 32'(o_any[0]), 32'h1);
      chk("t4_level_one",    0, 32'(o_lvl[0]), 32'h8);
      pins[0] = 4'b1111;
      ticks(20);
      chk("t4_any_none", 0, 32'(o_any[0]), 32'h0);

      // Reset while key 0 is held
      pins[0][0] = 1'b0;
      ticks(15);
      chk("t5_held", 0, 32'(o_lvl[0]), 32'h1);
      rst = 1'b1;
      tick();
      chk("t5_rst_outputs", 0,
          32'({o_lvl[0], o_prs[0], o_rel[0], o_lng[0], o_rpt[0], o_any[0]}), 32'h0);
      rst = 1'b0;
      for (int j = 0; j <= 12; j++) begin
         tick();
         if (j == 10) chk("t5_press_early", j, 32'(o_prs[0][0]), 32'h0);
         if (j == 11) chk("t5_press",       j, 32'(o_prs[0][0]), 32'h1);
      end
      pins[0][0] = 1'b1;
      ticks(20);

      // Repeat disabled instance: one long pulse, no repeats
      pins[1][1] = 1'b0;
      found = 1'b0;
      for (int j = 0; j < 30; j++) begin
         tick();
         if (o_prs[1][1]) begin found = 1'b1; break; end
      end
      chk("t6_press_seen", 1, 32'(found), 32'h1);
      n_long = 0; n_rpt = 0; long_off = -1;
      for (int j = 1; j <= 100; j++) begin
         tick();
         if (o_lng[1][1]) begin n_long++; long_off = j; end
         if (o_rpt[1] != 0) n_rpt++;
      end
      chk("t6_long_count",  1, 32'(n_long), 32'h1);
      chk("t6_long_offset", 1, 32'(long_off), 32'(L));
      chk("t6_rpt_none",    1, 32'(n_rpt), 32'h0);
      pins[1][1] = 1'b1;
      ticks(20);

      // Randomised stimulus against the model
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < NK; k++) rem[i][k] = int'($urandom_range(1, 20));
      for (int c = 0; c < 2500; c++) begin
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NK; k++) begin
               rem[i][k] = rem[i][k] - 1;
               if (rem[i][k] <= 0) begin
                  pins[i][k] = ~pins[i][k];
                  if ($urandom_range(0, 3) == 0) rem[i][k] = int'($urandom_range(30, 90));
                  else                           rem[i][k] = int'($urandom_range(1, 12));
               end
            end
         end
         rst = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 1'b0;
      pins[0] = 4'hF;
      pins[1] = 4'hF;
      ticks(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
